// File: rtl/pulse_period_monitor_pkg.sv
// Shared definitions for the pulse period monitor: state encoding,
// default widths and a small state-decoding helper.
package pulse_period_monitor_pkg;

    // Default parameter values
    localparam int CNT_W_DEF   = 16;
    localparam int PCNT_W_DEF  = 8;
    localparam int TIMEOUT_DEF = 1000;

    // Monitor FSM state encoding
    localparam logic [1:0] ST_IDLE       = 2'd0;
    localparam logic [1:0] ST_WAIT_FIRST = 2'd1;
    localparam logic [1:0] ST_MEASURE    = 2'd2;
    localparam logic [1:0] ST_LOST       = 2'd3;

    // The monitor counts as busy while it is looking for or timing edges.
    function automatic logic is_busy(input logic [1:0] st);
        return (st == ST_WAIT_FIRST) || (st == ST_MEASURE);
    endfunction

endpackage

// File: rtl/pulse_period_monitor_rise_edge_detector.sv
// Single-clock rising-edge detector. The delayed copy of d updates every
// cycle so a level held high produces exactly one rise.
module rise_edge_detector (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic rise
);

    logic pulse_q;

    // Register the previous input sample
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pulse_q <= 1'b0;
        end else begin
            pulse_q <= d;
        end
    end

    // Rise is high in the cycle the input goes from 0 to 1
    always_comb begin
        rise = d & ~pulse_q;
    end

endmodule

// File: rtl/pulse_period_monitor.sv
// Measures the edge-to-edge period of a pulse stream, counts pulses with
// saturation and flags loss of the pulse train after TIMEOUT silent cycles.
// Priority of controls: reset > enable low > clear > rise > timeout check.
module pulse_period_monitor
    import pulse_period_monitor_pkg::*;
#(
    parameter int CNT_W   = CNT_W_DEF,
    parameter int PCNT_W  = PCNT_W_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic              clear,
    input  logic              pulse_in,
    output logic [CNT_W-1:0]  period,
    output logic              period_valid,
    output logic [PCNT_W-1:0] pulse_count,
    output logic              timeout,
    output logic              busy
);

    logic              rise;
    logic [1:0]        state_q, state_d;
    logic [CNT_W-1:0]  period_q, period_d;
    logic              period_valid_q, period_valid_d;
    logic [PCNT_W-1:0] pcnt_q, pcnt_d;
    logic              timeout_q, timeout_d;
    logic [CNT_W-1:0]  gap_q, gap_d;
    logic [PCNT_W-1:0] pcnt_inc;

    rise_edge_detector u_edge (
        .clk   (clk),
        .reset (reset),
        .d     (pulse_in),
        .rise  (rise)
    );

    // Saturating increment of the pulse counter
    always_comb begin
        pcnt_inc = (pcnt_q == {PCNT_W{1'b1}}) ? pcnt_q : pcnt_q + PCNT_W'(1);
    end

    // Next-state and counter update logic
    always_comb begin
        state_d        = state_q;
        period_d       = period_q;
        period_valid_d = 1'b0;
        pcnt_d         = pcnt_q;
        timeout_d      = timeout_q;
        gap_d          = gap_q;

        if (!enable) begin
            // Outputs hold; a clear still zeroes them while parked in IDLE.
            state_d = ST_IDLE;
            if (clear) begin
                period_d  = '0;
                pcnt_d    = '0;
                timeout_d = 1'b0;
                gap_d     = '0;
            end
        end else if (clear) begin
            // A rise coinciding with clear is dropped.
            state_d   = ST_WAIT_FIRST;
            period_d  = '0;
            pcnt_d    = '0;
            timeout_d = 1'b0;
            gap_d     = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_WAIT_FIRST;
                end
                ST_WAIT_FIRST: begin
                    if (rise) begin
                        state_d = ST_MEASURE;
                        gap_d   = CNT_W'(1);
                        pcnt_d  = pcnt_inc;
                    end
                end
                ST_MEASURE: begin
                    if (rise) begin
                        period_d       = gap_q;
                        period_valid_d = 1'b1;
                        gap_d          = CNT_W'(1);
                        pcnt_d         = pcnt_inc;
                    end else if (gap_q == CNT_W'(TIMEOUT)) begin
                        state_d   = ST_LOST;
                        timeout_d = 1'b1;
                    end else begin
                        gap_d = gap_q + CNT_W'(1);
                    end
                end
                default: begin
                    // ST_LOST: the first edge back restarts timing without a period
                    if (rise) begin
                        state_d   = ST_MEASURE;
                        timeout_d = 1'b0;
                        gap_d     = CNT_W'(1);
                        pcnt_d    = pcnt_inc;
                    end
                end
            endcase
        end
    end

    // State and output registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            period_q       <= '0;
            period_valid_q <= 1'b0;
            pcnt_q         <= '0;
            timeout_q      <= 1'b0;
            gap_q          <= '0;
        end else begin
            state_q        <= state_d;
            period_q       <= period_d;
            period_valid_q <= period_valid_d;
            pcnt_q         <= pcnt_d;
            timeout_q      <= timeout_d;
            gap_q          <= gap_d;
        end
    end

    // Output mapping
    always_comb begin
        period       = period_q;
        period_valid = period_valid_q;
        pulse_count  = pcnt_q;
        timeout      = timeout_q;
        busy         = is_busy(state_q);
    end

endmodule

// File: doc/pulse_period_monitor.md
Name: pulse_period_monitor

Overview:
Downstream consumer of the single-cycle pulse generator stage. Detects rising edges on the pulse stream and measures the period between consecutive edges in clock cycles. Counts received pulses and flags a lost pulse train when no edge arrives within a timeout window. Feeds period and status to later display/checker stages.

Parameters:
CNT_W, 16, width of period counter and period output
PCNT_W, 8, width of pulse counter
TIMEOUT, 1000, max cycles between edges before loss is flagged; legal range 2 .. 2^CNT_W-2

Ports:
clk  input  1  system clock, rising-edge
reset  input  1  asynchronous, active-high reset
enable  input  1  monitor enable; low forces IDLE
clear  input  1  synchronous clear of counters and status
pulse_in  input  1  pulse stream from generator, same clock domain
period  output  CNT_W  last measured edge-to-edge period, in cycles
period_valid  output  1  one-cycle strobe; period updated this cycle
pulse_count  output  PCNT_W  rising edges seen while enabled, saturating
timeout  output  1  level; pulse train lost
busy  output  1  high in WAIT_FIRST or MEASURE

Behaviour:
- Clock and reset: one clock, clk. reset is asynchronous and active-high; it clears all state immediately on assertion, independent of clk.
- Reset values: period=0, period_valid=0, pulse_count=0, timeout=0, busy=0, state=IDLE, pulse_q=0, gap_cnt=0.
- Edge detect: pulse_q <= pulse_in every cycle, in all states including IDLE. rise = pulse_in & ~pulse_q, combinational. A pulse held high counts once.
- States: IDLE, WAIT_FIRST, MEASURE, LOST.
- IDLE: enable=1 -> WAIT_FIRST. Counters hold.
- WAIT_FIRST: rise -> MEASURE, gap_cnt<=1, pulse_count+1. No period_valid on the first edge.
- MEASURE: on rise: period<=gap_cnt, period_valid=1 next cycle, gap_cnt<=1, pulse_count+1. Without rise: gap_cnt+1. If gap_cnt==TIMEOUT and no rise -> LOST, timeout<=1.
- LOST: timeout held at 1. On rise -> MEASURE, timeout<=0, gap_cnt<=1, pulse_count+1, no period_valid.
- enable=0 in any state -> IDLE next cycle. Outputs period, pulse_count and timeout hold their values. busy=0. A rise in that cycle is ignored.
- Latency: edge at cycle t1 after edge at t0 gives period=t1-t0 and period_valid high in cycle t1+1.
- pulse_count saturates at 2^PCNT_W-1. gap_cnt cannot overflow because TIMEOUT < 2^CNT_W-1.
- clear=1 while enable=1: period=0, pulse_count=0, timeout=0, gap_cnt=0, state -> WAIT_FIRST. It has priority over a simultaneous rise, and that edge is dropped.
- clear=1 while enable=0: counters zeroed, state stays IDLE.
- Priority: reset > enable=0 > clear > rise > timeout check.
- Reset mid-measurement: all state lost; after release the monitor restarts from IDLE.

Decomposition:
- Shared package/include: state encoding localparams (IDLE=2'd0, WAIT_FIRST=2'd1, MEASURE=2'd2, LOST=2'd3) and default widths.
- One sub-module: rise_edge_detector (clk, reset, d, rise). It is reused by later stages.

Test Plan:
- Reset, enable=1, pulse_in 1-cycle high every 10 cycles, 4 pulses -> 3 period_valid strobes, period=10 each; pulse_count=4; timeout=0.
- pulse_in held high 7 cycles, then low 3, repeating -> one rise per cycle pattern; period=10; pulse_count increments once per pattern.
- TIMEOUT=20; one pulse, then silence -> timeout=1 exactly 20 cycles after the edge. Next pulse -> timeout=0, no period_valid. Following pulse at +10 -> period=10.
- clear asserted in the same cycle as a rise during MEASURE -> pulse_count=0, period=0, state WAIT_FIRST. The next two edges 10 apart -> period=10.
- PCNT_W=3; 10 pulses -> pulse_count saturates at 7.
- Async reset asserted mid-period, between clock edges -> all outputs 0 immediately. enable=0 then 1 while pulse_in is high -> no false edge counted.
